// File: rtl/dm_cache_ctrl.sv
// Direct-mapped, write-back, write-allocate cache controller between a CPU word port and a block memory.
// Define DM_CACHE_STATS_EN to add the c_hit_count_o / c_miss_count_o statistics outputs.
module dm_cache_ctrl #(
  parameter int c_block_size = 2,
  parameter int c_line_size  = 32,
  parameter int address_size = 32,
  parameter int c_index_size = 3,
  localparam int BW  = (2**c_block_size)*c_line_size,
  localparam int MAW = address_size-c_block_size-2
) (
  input  logic                    c_clk_i,
  input  logic                    c_reset_n_i,
  input  logic                    c_read_i,
  input  logic                    c_wr_i,
  input  logic [address_size-1:0] c_addr_i,
  input  logic [c_line_size-1:0]  c_wr_data_i,
  output logic [c_line_size-1:0]  c_read_data_o,
  output logic                    c_busywait_o,
  output logic                    mem_read_o,
  output logic                    mem_wr_o,
  output logic [MAW-1:0]          mem_addr_o,
  output logic [BW-1:0]           mem_wr_data_o,
  input  logic [BW-1:0]           mem_read_data_i,
`ifdef DM_CACHE_STATS_EN
  output logic [31:0]             c_hit_count_o,
  output logic [31:0]             c_miss_count_o,
`endif
  input  logic                    mem_busywait_i
);

  localparam int NW    = 2**c_block_size;
  localparam int LINES = 2**c_index_size;
  localparam int TW    = MAW-c_index_size;

  // WB_GAP guarantees one request-free cycle between the write-back and the fetch.
  typedef enum logic [2:0] {IDLE, WRITEBACK, WB_GAP, ALLOCATE, UPDATE} state_t;
  state_t state;

  logic [c_block_size-1:0]            word_sel;
  logic [c_index_size-1:0]            index;
  logic [TW-1:0]                      tag;
  logic                               unused_byte;
  logic [LINES-1:0]                   valid, dirty;
  logic [TW-1:0]                      tags [LINES];
  logic [NW-1:0][c_line_size-1:0]     data [LINES];
  logic [NW-1:0][c_line_size-1:0]     fill;
  logic                               seen_busy;
  logic                               access, hit, done;

  assign word_sel    = c_addr_i[c_block_size+1:2];
  assign index       = c_addr_i[c_block_size+2 +: c_index_size];
  assign tag         = c_addr_i[address_size-1 -: TW];
  assign unused_byte = ^c_addr_i[1:0];
  assign access      = c_read_i | c_wr_i;
  assign hit         = valid[index] && (tags[index] == tag);
  assign done        = seen_busy && !mem_busywait_i;

  always_comb begin
    c_busywait_o  = 1'b1;
    c_read_data_o = '0;
    mem_read_o    = 1'b0;
    mem_wr_o      = 1'b0;
    mem_addr_o    = '0;
    mem_wr_data_o = '0;
    case (state)
      IDLE: begin
        c_busywait_o = access && !hit;
        if (hit) c_read_data_o = data[index][word_sel];
      end
      WRITEBACK: begin
        mem_wr_o      = 1'b1;
        mem_addr_o    = {tags[index], index};
        mem_wr_data_o = data[index];
      end
      ALLOCATE: begin
        mem_read_o = 1'b1;
        mem_addr_o = {tag, index};
      end
      default: ;
    endcase
  end

  always_ff @(posedge c_clk_i or negedge c_reset_n_i) begin
    if (!c_reset_n_i) begin
      state     <= IDLE;
      valid     <= '0;
      dirty     <= '0;
      seen_busy <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (access) begin
            if (hit) begin
              if (c_wr_i) dirty[index] <= 1'b1;
            end else if (valid[index] && dirty[index]) begin
              state <= WRITEBACK;
            end else begin
              state <= ALLOCATE;
            end
          end
        end
        WRITEBACK, ALLOCATE: begin
          if (done) begin
            seen_busy <= 1'b0;
            state     <= (state == WRITEBACK) ? WB_GAP : UPDATE;
          end else if (mem_busywait_i) begin
            seen_busy <= 1'b1;
          end
        end
        WB_GAP: state <= ALLOCATE;
        UPDATE: begin
          valid[index] <= 1'b1;
          dirty[index] <= 1'b0;
          state        <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Line payload needs no reset: it is only observed through valid lines.
  always_ff @(posedge c_clk_i) begin
    if (state == IDLE && c_wr_i && hit) data[index][word_sel] <= c_wr_data_i;
    if (state == ALLOCATE && done) fill <= mem_read_data_i;
    if (state == UPDATE) begin
      data[index] <= fill;
      tags[index] <= tag;
    end
  end

`ifdef DM_CACHE_STATS_EN
  logic from_update;

  always_ff @(posedge c_clk_i or negedge c_reset_n_i) begin
    if (!c_reset_n_i) begin
      from_update    <= 1'b0;
      c_hit_count_o  <= '0;
      c_miss_count_o <= '0;
    end else begin
      from_update <= (state == UPDATE);
      if (state == IDLE && access) begin
        if (!hit) c_miss_count_o <= c_miss_count_o + 32'd1;
        else if (!from_update) c_hit_count_o <= c_hit_count_o + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_dm_cache_ctrl.sv
// Self-checking bench for dm_cache_ctrl: vector table plus hand sequences for dirty miss,
// slow memory and reset mid-fetch; a behavioural block memory answers the busywait handshake.
module tb_dm_cache_ctrl;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         c_read, c_wr;
  logic [31:0]  c_addr, c_wr_data, c_read_data;
  logic         c_busywait;
  logic         mem_read, mem_wr, mem_busywait;
  logic [27:0]  mem_addr;
  logic [127:0] mem_wr_data, mem_read_data;
`ifdef DM_CACHE_STATS_EN
  logic [31:0]  hit_count, miss_count;
`endif

  int total = 0;
  int bad   = 0;
  int exp_hits = 0;
  int exp_misses = 0;

  always #5 clk = ~clk;

  dm_cache_ctrl #(.c_block_size(2), .c_line_size(32), .address_size(32), .c_index_size(3)) dut (
    .c_clk_i(clk), .c_reset_n_i(rst_n), .c_read_i(c_read), .c_wr_i(c_wr),
    .c_addr_i(c_addr), .c_wr_data_i(c_wr_data), .c_read_data_o(c_read_data),
    .c_busywait_o(c_busywait), .mem_read_o(mem_read), .mem_wr_o(mem_wr),
    .mem_addr_o(mem_addr), .mem_wr_data_o(mem_wr_data), .mem_read_data_i(mem_read_data),
`ifdef DM_CACHE_STATS_EN
    .c_hit_count_o(hit_count), .c_miss_count_o(miss_count),
`endif
    .mem_busywait_i(mem_busywait)
  );

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- block memory model with scoreboard of expected requests
  typedef struct { bit wr; logic [27:0] addr; logic [127:0] data; } mreq_t;
  mreq_t        mem_q[$];
  mreq_t        cur, e;
  logic [127:0] mem_blk [64];
  int           pre_delay = 1;
  int           lat = 2;
  int           phase = 0;
  int           cnt = 0;

  initial begin
    for (int i = 0; i < 64; i++)
      for (int w = 0; w < 4; w++)
        mem_blk[i][w*32 +: 32] = 32'hB000_0000 | 32'(i << 4) | 32'(w);
    mem_blk[1] = {32'hD, 32'hC, 32'hB, 32'hA};
    mem_busywait  = 1'b0;
    mem_read_data = '0;
    forever begin
      @(posedge clk); #1;
      if (!rst_n) begin
        phase = 0;
        mem_busywait = 1'b0;
      end else begin
        case (phase)
          0: if (mem_read || mem_wr) begin
            cur.wr = mem_wr; cur.addr = mem_addr; cur.data = mem_wr_data;
            check("mem_rd_and_wr", 128'(mem_read & mem_wr), 128'd0);
            if (mem_q.size() == 0) begin
              total++; bad++;
              $display("FAIL mem_unexpected: got wr=%0d addr=%0h expected no request", cur.wr, cur.addr);
            end else begin
              e = mem_q.pop_front();
              check("mem_type", 128'(cur.wr), 128'(e.wr));
              check("mem_addr", 128'(cur.addr), 128'(e.addr));
              if (e.wr) check("mem_wdata", cur.data, e.data);
            end
            cnt = pre_delay;
            if (cnt == 0) begin mem_busywait = 1'b1; cnt = lat; phase = 2; end
            else phase = 1;
          end
          1, 2: begin
            check("mem_req_held", 128'({mem_read, mem_wr}), 128'({!cur.wr, cur.wr}));
            check("mem_addr_held", 128'(mem_addr), 128'(cur.addr));
            cnt--;
            if (cnt == 0) begin
              if (phase == 1) begin
                mem_busywait = 1'b1; cnt = lat; phase = 2;
              end else begin
                mem_busywait = 1'b0;
                if (cur.wr) mem_blk[cur.addr[5:0]] = cur.data;
                else mem_read_data = mem_blk[cur.addr[5:0]];
                phase = 3;
              end
            end
          end
          default: begin
            check("mem_req_dropped", 128'(mem_read | mem_wr), 128'd0);
            phase = 0;
          end
        endcase
      end
    end
  end

  // ---------------- CPU side
  logic [31:0] rd_q[$];

  task automatic cpu_access(input bit wr, input logic [31:0] addr, input logic [31:0] wdata,
                            input bit exp_hit, input logic [31:0] exp_rd);
    int stalls = 0;
    bit ok = 1'b0;
    c_wr = wr; c_read = !wr; c_addr = addr; c_wr_data = wdata;
    if (!wr) rd_q.push_back(exp_rd);
    if (exp_hit) exp_hits++; else exp_misses++;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (!c_busywait) begin ok = 1'b1; break; end
      stalls++;
    end
    if (!ok) begin
      total++; bad++;
      $display("FAIL timeout@%h: got busywait stuck expected completion", addr);
      if (!wr) void'(rd_q.pop_front());
    end else begin
      if (!wr) check($sformatf("rd_data@%h", addr), 128'(c_read_data), 128'(rd_q.pop_front()));
      check($sformatf("no_stall@%h", addr), 128'(stalls == 0), 128'(exp_hit));
    end
    @(posedge clk); #1;
    c_read = 1'b0; c_wr = 1'b0;
  endtask

  typedef struct { bit wr; logic [31:0] addr; logic [31:0] wdata; bit exp_hit;
                   logic [31:0] exp_rd; bit mem_rd; logic [27:0] mem_addr; } vec_t;
  vec_t vecs [10];

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{1'b0, 32'h10, 32'h0,        1'b0, 32'hA,        1'b1, 28'h1};
    vecs[1] = '{1'b0, 32'h18, 32'h0,        1'b1, 32'hC,        1'b0, 28'h0};
    vecs[2] = '{1'b1, 32'h14, 32'h12345678, 1'b1, 32'h0,        1'b0, 28'h0};
    vecs[3] = '{1'b0, 32'h14, 32'h0,        1'b1, 32'h12345678, 1'b0, 28'h0};
    vecs[4] = '{1'b0, 32'h1C, 32'h0,        1'b1, 32'hD,        1'b0, 28'h0};
    vecs[5] = '{1'b0, 32'h24, 32'h0,        1'b0, 32'hB0000021, 1'b1, 28'h2};
    vecs[6] = '{1'b1, 32'h2C, 32'hCAFEF00D, 1'b1, 32'h0,        1'b0, 28'h0};
    vecs[7] = '{1'b1, 32'h30, 32'h55AA55AA, 1'b0, 32'h0,        1'b1, 28'h3};
    vecs[8] = '{1'b0, 32'h30, 32'h0,        1'b1, 32'h55AA55AA, 1'b0, 28'h0};
    vecs[9] = '{1'b0, 32'h2C, 32'h0,        1'b1, 32'hCAFEF00D, 1'b0, 28'h0};

    rst_n = 1'b0; c_read = 1'b0; c_wr = 1'b0; c_addr = '0; c_wr_data = '0;
    repeat (2) @(posedge clk); #1;
    check("rst_busywait", 128'(c_busywait), 128'd0);
    check("rst_mem_read", 128'(mem_read), 128'd0);
    check("rst_mem_wr", 128'(mem_wr), 128'd0);
    check("rst_mem_addr", 128'(mem_addr), 128'd0);
    check("rst_mem_wdata", mem_wr_data, 128'd0);
    check("rst_read_data", 128'(c_read_data), 128'd0);
    c_read = 1'b1; c_addr = 32'h10; #1;
    check("rst_busywait_miss", 128'(c_busywait), 128'd1);
    c_read = 1'b0;
    @(posedge clk); #3; rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 10; i++) begin
      if (vecs[i].mem_rd) mem_q.push_back('{1'b0, vecs[i].mem_addr, 128'd0});
      cpu_access(vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].exp_hit, vecs[i].exp_rd);
    end

    // dirty victim with slow memory: write-back, gap, then fetch of block 9
    pre_delay = 3;
    mem_q.push_back('{1'b1, 28'h1, {32'hD, 32'hC, 32'h12345678, 32'hA}});
    mem_q.push_back('{1'b0, 28'h9, 128'd0});
    cpu_access(1'b0, 32'h90, 32'h0, 1'b0, 32'hB0000090);
    pre_delay = 1;
    mem_q.push_back('{1'b0, 28'h1, 128'd0});
    cpu_access(1'b0, 32'h14, 32'h0, 1'b0, 32'h12345678);
`ifdef DM_CACHE_STATS_EN
    check("hit_count", 128'(hit_count), 128'(exp_hits));
    check("miss_count", 128'(miss_count), 128'(exp_misses));
`endif

    // reset while the fetch request is outstanding
    pre_delay = 4;
    mem_q.push_back('{1'b0, 28'h5, 128'd0});
    c_read = 1'b1; c_addr = 32'h58;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (mem_read) break;
    end
    check("alloc_seen", 128'(mem_read), 128'd1);
    @(posedge clk); #2;
    rst_n = 1'b0; #1;
    check("rst_drops_mem_read", 128'(mem_read), 128'd0);
    check("rst_busywait_miss2", 128'(c_busywait), 128'd1);
    c_read = 1'b0;
    @(posedge clk); @(posedge clk); #3;
    rst_n = 1'b1;
    exp_hits = 0; exp_misses = 0;
    pre_delay = 1;
    @(posedge clk); #1;
    mem_q.push_back('{1'b0, 28'h1, 128'd0});
    cpu_access(1'b0, 32'h18, 32'h0, 1'b0, 32'hC);
    cpu_access(1'b0, 32'h10, 32'h0, 1'b1, 32'hA);
`ifdef DM_CACHE_STATS_EN
    check("hit_count_after_rst", 128'(hit_count), 128'(exp_hits));
    check("miss_count_after_rst", 128'(miss_count), 128'(exp_misses));
`endif

    repeat (3) @(posedge clk); #1;
    check("mem_q_drained", 128'(mem_q.size()), 128'd0);
    check("rd_q_drained", 128'(rd_q.size()), 128'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dm_cache_ctrl.md
# dm_cache_ctrl

- Direct-mapped, write-back, write-allocate cache controller.
- Sits between the CPU load/store port and the block memory, and acts as the initiator of the block read/write busywait protocol that the memory responds to.
- Serves word hits with no stall.
- On a miss it stalls the CPU, writes back a dirty victim block, fetches the missing block, then completes the access.

## Interface
Parameters:
- c_block_size, 2: log2 of words per block.
- c_line_size, 32: word width in bits.
- address_size, 32: CPU byte-address width.
- c_index_size, 3: log2 of the number of cache lines (8).

Ports (BW = 2**c_block_size*c_line_size, MAW = address_size-c_block_size-2):
- c_clk_i  in  1  clock. All state updates occur on the rising edge.
- c_reset_n_i  in  1  reset, asynchronous, active-low.
- c_read_i  in  1  CPU read request, held until c_busywait_o is low.
- c_wr_i  in  1  CPU write request, held until c_busywait_o is low.
- c_addr_i  in  address_size  CPU byte address. Field layout:
  - [1:0] byte, ignored.
  - [c_block_size+1:2] word.
  - next c_index_size bits: index.
  - remaining bits: tag.
- c_wr_data_i  in  c_line_size  CPU write word.
- c_read_data_o  out  c_line_size  CPU read word.
- c_busywait_o  out  1  CPU stall.
- mem_read_o  out  1  block read request.
- mem_wr_o  out  1  block write request.
- mem_addr_o  out  MAW  block address, equal to byte address [address_size-1:c_block_size+2].
- mem_wr_data_o  out  BW  victim block. Word 0 is in bits [c_line_size-1:0].
- mem_read_data_i  in  BW  fetched block, same word ordering as mem_wr_data_o.
- mem_busywait_i  in  1  memory busy.

## Operation
- Storage per line: valid bit, dirty bit, tag, BW data.
- hit = valid & (stored tag == address tag).
- States:
  - IDLE: compare.
  - WRITEBACK: mem_wr_o=1. mem_addr_o = {stored tag, index}. mem_wr_data_o = stored block.
  - ALLOCATE: mem_read_o=1. mem_addr_o = {address tag, index}.
  - UPDATE: install the fetched block.
- IDLE behaviour:
  - access = c_read_i | c_wr_i.
  - c_busywait_o = access & ~hit, combinational.
  - Read hit: c_read_data_o = selected word, combinational; no state change.
  - Write hit: at the edge, write c_wr_data_i into the word and set dirty.
  - Miss with valid & dirty: next state WRITEBACK. Otherwise: next state ALLOCATE.
- WRITEBACK/ALLOCATE handshake:
  - The request is held with a constant address until the controller samples mem_busywait_i=1 and later samples mem_busywait_i=0.
  - Internal flag seen_busy is set on the first mem_busywait_i=1 and cleared on state exit.
  - Completion is seen_busy & ~mem_busywait_i at a rising edge.
  - On completion: WRITEBACK goes to ALLOCATE; ALLOCATE latches mem_read_data_i and goes to UPDATE.
- UPDATE: write the latched block, tag ← address tag, valid=1, dirty=0, then go to IDLE. The pending access then hits and completes as above.
- In WRITEBACK, ALLOCATE and UPDATE, c_busywait_o = 1.
- mem_read_o and mem_wr_o are decoded from state only; they are never both 1.
- Outside WRITEBACK/ALLOCATE: mem_read_o = mem_wr_o = 0, mem_addr_o = 0, mem_wr_data_o = 0.
- c_read_i and c_wr_i both high: treated as a write.
- CPU inputs are sampled only in IDLE. Changing them during a stall is a protocol violation, and the result is undefined.

## Timing
- Reset while c_reset_n_i=0:
  - State IDLE.
  - All valid and dirty bits 0; seen_busy 0.
  - mem_read_o=0, mem_wr_o=0, mem_addr_o=0, mem_wr_data_o=0.
  - c_read_data_o=0.
  - c_busywait_o=0, or the miss value once access is applied.
- Reset mid-miss aborts the transaction immediately and asynchronously. The memory request drops in the same instant.
- Hit latency: 0 cycles; no stall.
- Clean miss: 1 edge to ALLOCATE, then memory latency T until completion, then 1 cycle UPDATE. The access completes at the first IDLE cycle after UPDATE.
- Dirty miss: adds a WRITEBACK of T_w cycles before ALLOCATE.
- The request is deasserted in the cycle after the completion edge. There is always at least one cycle with mem_read_o=mem_wr_o=0 between WRITEBACK and ALLOCATE: the ALLOCATE request starts one cycle after the WRITEBACK completion.
- mem_busywait_i=0 before seen_busy is set is not completion.

## Configuration
- Macro: DM_CACHE_STATS_EN.
- Defined:
  - Adds outputs c_hit_count_o and c_miss_count_o, 32 bits each.
  - Each counter resets to 0 and wraps at 2^32.
  - c_hit_count_o increments once per completed access that hit on first sampling.
  - c_miss_count_o increments on each IDLE→WRITEBACK or IDLE→ALLOCATE transition.
  - The post-UPDATE completion does not count as a hit.
- Undefined: no ports, no counter logic.

## Test plan
- Reset, then read 0x0000_0010 with memory block 1 = {W3..W0} = {D,C,B,A}:
  - mem_read_o=1, mem_addr_o=0x000_0001, mem_wr_o never 1.
  - After UPDATE: c_read_data_o=0xA and c_busywait_o falls.
  - Stats (with DM_CACHE_STATS_EN): miss=1.
- After the fill above, read 0x0000_0018: c_read_data_o=0xC in the same cycle, c_busywait_o=0 throughout, hit count +1.
- Write 0x1234_5678 to 0x0000_0014 (hit): no stall, line dirty. Then read 0x0000_0014 returns 0x1234_5678.
- Then read 0x0000_0090 (same index 1, tag 1):
  - WRITEBACK with mem_addr_o=0x000_0001 and mem_wr_data_o={D,C,0x12345678,A}.
  - At least one idle memory cycle.
  - ALLOCATE with mem_addr_o=0x000_0009.
  - Final data is word 0 of block 9.
- Memory holds mem_busywait_i=0 for 3 cycles after the request before asserting: the controller holds the request and does not complete early.
- Assert c_reset_n_i low during ALLOCATE: mem_read_o drops immediately. After release, a read of the previously filled 0x0000_0018 misses again.
